// File: rtl/bitstream_pkg.sv
// Shared definitions for the bitstream packer and the arbiter that feeds it.
package bitstream_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSetaddr,
      StGap,
      StArb,
      StOwn
   } arb_state_e;

   localparam int unsigned BitsWDefault = 16;
   localparam int unsigned LenWDefault  = 4;
   localparam int unsigned AddrW        = 32;
   // The packer advances its write address by one 16-bit word per flush.
   localparam int unsigned AddrIncr     = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
   parameter int unsigned N_REQ = 3,
   localparam int unsigned PtrW = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PtrW-1:0]  ptr_i,
   output logic [N_REQ-1:0] gnt_o
);

   always_comb begin
      logic [PtrW-1:0] idx;
      logic            found;
      gnt_o = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = PtrW'((32'(ptr_i) + i) % N_REQ);
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bitstream_arbiter.sv
// Front-end for the bitstream packer: loads the frame base address, then lends
// the packer to one code producer at a time, locked until that producer's last code.
module bitstream_arbiter
   import bitstream_pkg::*;
#(
   parameter int unsigned N_REQ  = 3,
   parameter int unsigned BITS_W = BitsWDefault,
   parameter int unsigned LEN_W  = LenWDefault
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    stop,
   input  logic [AddrW-1:0]        base_addr,
   output logic                    busy,
   output logic                    overflow,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*BITS_W-1:0] req_bits,
   input  logic [N_REQ*LEN_W-1:0]  req_len,
   input  logic [N_REQ-1:0]        req_last,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        ack,
   input  logic                    bs_rdy,
   input  logic                    bs_full,
   output logic                    bs_en,
   output logic                    bs_setaddr,
   output logic [BITS_W-1:0]       bs_in_bits,
   output logic [LEN_W-1:0]        bs_in_len,
   output logic [AddrW-1:0]        bs_abase
);

   localparam int unsigned PtrW = $clog2(N_REQ);

   arb_state_e         state_q, state_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic [PtrW-1:0]    ptr_q, ptr_d;
   logic [AddrW-1:0]   addr_q, addr_d;
   logic [AddrW-1:0]   abase_q, abase_d;
   logic [BITS_W-1:0]  bits_q, bits_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               en_q, en_d;
   logic               setaddr_q, setaddr_d;
   logic               overflow_q, overflow_d;
   logic               busy_q, busy_d;

   logic [N_REQ-1:0]   pick;
   logic               own_req;
   logic               own_last;
   logic [BITS_W-1:0]  own_bits;
   logic [LEN_W-1:0]   own_len;
   logic [PtrW-1:0]    own_nxt_ptr;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_rr_arbiter (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (pick)
   );

   // Route the current owner's code; gnt_q is one-hot whenever it is non-zero.
   always_comb begin
      own_req     = 1'b0;
      own_last    = 1'b0;
      own_bits    = '0;
      own_len     = '0;
      own_nxt_ptr = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (gnt_q[i]) begin
            own_req     = req[i];
            own_last    = req_last[i];
            own_bits    = req_bits[i*BITS_W +: BITS_W];
            own_len     = req_len[i*LEN_W +: LEN_W];
            own_nxt_ptr = PtrW'((i + 1) % N_REQ);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      ack_d      = '0;
      ptr_d      = ptr_q;
      addr_d     = addr_q;
      abase_d    = '0;
      bits_d     = '0;
      len_d      = '0;
      en_d       = 1'b0;
      setaddr_d  = 1'b0;
      overflow_d = overflow_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               addr_d     = base_addr;
               overflow_d = 1'b0;
               state_d    = StSetaddr;
            end
         end
         StSetaddr: begin
            if (bs_rdy) begin
               setaddr_d = 1'b1;
               abase_d   = addr_q;
               state_d   = StGap;
            end
         end
         StGap: begin
            state_d = (gnt_q != '0) ? StOwn : StArb;
         end
         StArb: begin
            if (stop) begin
               state_d = StIdle;
            end else if (req != '0) begin
               gnt_d   = pick;
               state_d = StOwn;
            end
         end
         StOwn: begin
            if (own_req && bs_full) begin
               overflow_d = 1'b1;
            end else if (own_req && bs_rdy) begin
               ack_d = gnt_q;
               // A zero-length code only carries the packet-end marker.
               if (own_len != '0) begin
                  en_d   = 1'b1;
                  bits_d = own_bits;
                  len_d  = own_len;
               end
               if (own_last) begin
                  gnt_d = '0;
                  ptr_d = own_nxt_ptr;
               end
               state_d = StGap;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         gnt_q      <= '0;
         ack_q      <= '0;
         ptr_q      <= '0;
         addr_q     <= '0;
         abase_q    <= '0;
         bits_q     <= '0;
         len_q      <= '0;
         en_q       <= 1'b0;
         setaddr_q  <= 1'b0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         ack_q      <= ack_d;
         ptr_q      <= ptr_d;
         addr_q     <= addr_d;
         abase_q    <= abase_d;
         bits_q     <= bits_d;
         len_q      <= len_d;
         en_q       <= en_d;
         setaddr_q  <= setaddr_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
      end
   end

   assign busy       = busy_q;
   assign overflow   = overflow_q;
   assign gnt        = gnt_q;
   assign ack        = ack_q;
   assign bs_en      = en_q;
   assign bs_setaddr = setaddr_q;
   assign bs_in_bits = bits_q;
   assign bs_in_len  = len_q;
   assign bs_abase   = abase_q;

endmodule
